// File: rtl/hub75_scan_scheduler_pkg.sv
// Shared definitions for the HUB75 scan scheduler: default panel geometry
// and the scan state encoding.
package hub75_scan_scheduler_pkg;

    localparam int DEF_COLUMNS  = 64;
    localparam int DEF_ROW_BITS = 4;
    localparam int DEF_PLANES   = 4;
    localparam int DEF_BASE_OE  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4,
        ST_ADVANCE = 3'd5
    } state_e;

endpackage

// File: rtl/hub75_scan_scheduler_oe_window.sv
// Brightness-scaled output-enable window: captures the plane window and the
// on-time in LATCH, then counts DISPLAY cycles and drives the active-low OE.
module hub75_oe_window
    import hub75_scan_scheduler_pkg::*;
#(
    parameter int PLANES  = DEF_PLANES,
    parameter int BASE_OE = DEF_BASE_OE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      run,
    input  logic [$clog2(PLANES)-1:0] plane,
    input  logic [7:0]                brightness,
    output logic                      hub75_oe,
    output logic                      done
);

    localparam int WIN_W  = $clog2(BASE_OE) + PLANES;
    localparam int PROD_W = WIN_W + 8;

    logic [WIN_W-1:0]  window_s;
    logic [PROD_W-1:0] prod_s;
    logic [WIN_W-1:0]  on_s;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W-1:0]  on_q, on_d;
    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic              oe_q, oe_d;

    // On-time is the plane window scaled by brightness/256, so the window
    // length (and thus the frame period) never depends on brightness.
    always_comb begin
        window_s = WIN_W'(BASE_OE) << plane;
        prod_s   = PROD_W'(window_s) * PROD_W'(brightness);
        on_s     = prod_s[PROD_W-1:8];
        done     = (cnt_q == (win_q - WIN_W'(1)));
    end

    // Next-state for the window counter; OE for the upcoming cycle is low
    // only while the upcoming display index is below the on-time.
    always_comb begin
        win_d = win_q;
        on_d  = on_q;
        cnt_d = cnt_q;
        oe_d  = 1'b1;
        if (load) begin
            win_d = window_s;
            on_d  = on_s;
            cnt_d = {WIN_W{1'b0}};
            oe_d  = (on_s == {WIN_W{1'b0}});
        end else if (run && !done) begin
            cnt_d = cnt_q + WIN_W'(1);
            oe_d  = !((cnt_q + WIN_W'(1)) < on_q);
        end else begin
            oe_d  = 1'b1;
        end
    end

    // Window registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= {WIN_W{1'b0}};
            on_q  <= {WIN_W{1'b0}};
            cnt_q <= {WIN_W{1'b0}};
            oe_q  <= 1'b1;
        end else begin
            win_q <= win_d;
            on_q  <= on_d;
            cnt_q <= cnt_d;
            oe_q  <= oe_d;
        end
    end

    assign hub75_oe = oe_q;

endmodule

// File: rtl/hub75_scan_scheduler.sv
// HUB75 scan scheduler: shifts a row per bit-plane, latches it, shows it for
// a binary-weighted window and owns the double-buffer bank flip.
module hub75_scan_scheduler
    import hub75_scan_scheduler_pkg::*;
#(
    parameter int COLUMNS  = DEF_COLUMNS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int PLANES   = DEF_PLANES,
    parameter int BASE_OE  = DEF_BASE_OE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [7:0]                 brightness,
    input  logic                       flip_req,
    output logic [$clog2(COLUMNS)-1:0] col_addr,
    output logic [ROW_BITS-1:0]        row_addr,
    output logic [$clog2(PLANES)-1:0]  plane,
    output logic                       bank_sel,
    output logic                       shift_en,
    output logic                       hub75_latch,
    output logic                       hub75_oe,
    output logic                       flip_ack,
    output logic                       frame_start
);

    localparam int COL_W = $clog2(COLUMNS);
    localparam int PL_W  = $clog2(PLANES);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic                bank_q, bank_d;
    logic                pending_q, pending_d;
    logic                shift_en_q, shift_en_d;
    logic                latch_q, latch_d;
    logic                flip_ack_q, flip_ack_d;
    logic                frame_start_q, frame_start_d;

    logic                plane_wrap_s;
    logic                row_wrap_s;
    logic [PL_W-1:0]     plane_inc_s;
    logic [ROW_BITS-1:0] row_inc_s;
    logic                load_s;
    logic                run_s;
    logic                oe_done_s;

    // Scan position after the current plane completes.
    always_comb begin
        plane_wrap_s = (plane_q == PL_W'(PLANES - 1));
        row_wrap_s   = plane_wrap_s && (row_q == {ROW_BITS{1'b1}});
        plane_inc_s  = plane_wrap_s ? {PL_W{1'b0}} : (plane_q + PL_W'(1));
        row_inc_s    = plane_wrap_s ? (row_q + ROW_BITS'(1)) : row_q;
        load_s       = (state_q == ST_LATCH);
        run_s        = (state_q == ST_DISPLAY);
    end

    // Scan sequencing; shift_en trails the column address by one cycle to
    // line up with the pixel RAM read data.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        plane_d       = plane_q;
        bank_d        = bank_q;
        pending_d     = pending_q | flip_req;
        shift_en_d    = (state_q == ST_SHIFT);
        latch_d       = 1'b0;
        flip_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d       = ST_SHIFT;
                    col_d         = {COL_W{1'b0}};
                    frame_start_d = (row_q == {ROW_BITS{1'b0}}) && (plane_q == {PL_W{1'b0}});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (col_q == COL_W'(COLUMNS - 1)) begin
                    state_d = ST_FLUSH;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_LATCH;
                latch_d = 1'b1;
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (oe_done_s) begin
                    state_d = ST_ADVANCE;
                end else begin
                    state_d = ST_DISPLAY;
                end
            end
            ST_ADVANCE: begin
                plane_d = plane_inc_s;
                row_d   = row_inc_s;
                // A request arriving in this very cycle still counts for this frame.
                if (row_wrap_s && (pending_q || flip_req)) begin
                    bank_d     = !bank_q;
                    flip_ack_d = 1'b1;
                    pending_d  = 1'b0;
                end else begin
                    bank_d = bank_q;
                end
                if (enable) begin
                    state_d       = ST_SHIFT;
                    col_d         = {COL_W{1'b0}};
                    frame_start_d = (row_inc_s == {ROW_BITS{1'b0}}) && (plane_inc_s == {PL_W{1'b0}});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            col_q         <= {COL_W{1'b0}};
            row_q         <= {ROW_BITS{1'b0}};
            plane_q       <= {PL_W{1'b0}};
            bank_q        <= 1'b0;
            pending_q     <= 1'b0;
            shift_en_q    <= 1'b0;
            latch_q       <= 1'b0;
            flip_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            bank_q        <= bank_d;
            pending_q     <= pending_d;
            shift_en_q    <= shift_en_d;
            latch_q       <= latch_d;
            flip_ack_q    <= flip_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    hub75_oe_window #(
        .PLANES  (PLANES),
        .BASE_OE (BASE_OE)
    ) u_oe_window (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .run        (run_s),
        .plane      (plane_q),
        .brightness (brightness),
        .hub75_oe   (hub75_oe),
        .done       (oe_done_s)
    );

    assign col_addr    = col_q;
    assign row_addr    = row_q;
    assign plane       = plane_q;
    assign bank_sel    = bank_q;
    assign shift_en    = shift_en_q;
    assign hub75_latch = latch_q;
    assign flip_ack    = flip_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Self-checking bench for hub75_scan_scheduler: an offset-within-plane model
// checked every cycle, a brightness table, and directed corner sequences.
module tb_hub75_scan_scheduler;

    localparam int COLS = 64;
    localparam int RB   = 4;
    localparam int NPL  = 4;
    localparam int BOE  = 32;

    logic       clk = 1'b0;
    logic       reset, enable, flip_req;
    logic [7:0] brightness;
    logic [5:0] col_addr;
    logic [3:0] row_addr;
    logic [1:0] plane;
    logic       bank_sel, shift_en, hub75_latch, hub75_oe, flip_ack, frame_start;

    always #5 clk = ~clk;

    hub75_scan_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .brightness  (brightness),
        .flip_req    (flip_req),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .plane       (plane),
        .bank_sel    (bank_sel),
        .shift_en    (shift_en),
        .hub75_latch (hub75_latch),
        .hub75_oe    (hub75_oe),
        .flip_ack    (flip_ack),
        .frame_start (frame_start)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: position is an offset t inside the current plane period.
    bit m_idle, m_bank, m_pend, m_ack, m_fs;
    int m_t, m_row, m_plane, m_col, m_on;

    typedef struct {
        int p;
        int b;
        int exp_low;
    } vec_t;
    vec_t vecs[10];

    function automatic int win(input int p);
        return BOE << p;
    endfunction

    task automatic model_step(input bit en, input int br, input bit fr, input bit rst);
        int w;
        bit pend_n;
        if (rst) begin
            m_idle = 1; m_t = 0; m_row = 0; m_plane = 0; m_col = 0;
            m_bank = 0; m_pend = 0; m_ack = 0; m_fs = 0; m_on = 0;
            return;
        end
        w = win(m_plane);
        pend_n = m_pend | fr;
        m_ack = 0;
        m_fs = 0;
        if (m_idle) begin
            if (en) begin
                m_idle = 0; m_t = 0;
                m_fs = (m_row == 0 && m_plane == 0);
            end
        end else if (m_t == COLS + 2 + w) begin
            m_plane++;
            if (m_plane == NPL) begin
                m_plane = 0;
                m_row = (m_row + 1) % (1 << RB);
                if (m_row == 0 && pend_n) begin
                    m_bank = !m_bank; m_ack = 1; pend_n = 0;
                end
            end
            if (en) begin
                m_t = 0;
                m_fs = (m_row == 0 && m_plane == 0);
            end else begin
                m_idle = 1;
            end
        end else begin
            if (m_t == COLS + 1) m_on = (w * br) >> 8;
            m_t++;
        end
        m_pend = pend_n;
        if (!m_idle) m_col = (m_t < COLS) ? m_t : COLS - 1;
    endtask

    task automatic check_model();
        logic [17:0] got, want;
        bit e_oe, e_se, e_la;
        e_se = !m_idle && m_t >= 1 && m_t <= COLS;
        e_la = !m_idle && m_t == COLS + 1;
        e_oe = !(!m_idle && m_t >= COLS + 2 && m_t < COLS + 2 + win(m_plane)
                 && (m_t - COLS - 2) < m_on);
        got  = {col_addr, row_addr, plane, bank_sel, shift_en, hub75_latch, hub75_oe, flip_ack, frame_start};
        want = {6'(m_col), 4'(m_row), 2'(m_plane), m_bank, e_se, e_la, e_oe, m_ack, m_fs};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL model cycle=%0d col/row/pl/bank/se/la/oe/ack/fs got=%b want=%b", cyc, got, want);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input bit en, input int br, input bit fr, input bit rst);
        reset = rst;
        enable = en;
        brightness = br[7:0];
        flip_req = fr;
        model_step(en, br, fr, rst);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    int low, act, se_cnt, acks, n, found, row_keep;
    int fs_at, latch_at, first_low, plane99, col99;
    bit ren;

    initial begin
        vecs[0] = '{0, 255, 31};
        vecs[1] = '{3, 128, 128};
        vecs[2] = '{2, 0, 0};
        vecs[3] = '{3, 255, 255};
        vecs[4] = '{1, 64, 16};
        vecs[5] = '{2, 200, 100};
        vecs[6] = '{0, 3, 0};
        vecs[7] = '{0, 8, 1};
        vecs[8] = '{3, 1, 1};
        vecs[9] = '{1, 255, 63};

        reset = 1'b1; enable = 1'b0; brightness = 8'd0; flip_req = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_int("rst_oe", hub75_oe, 1);
        expect_int("rst_bank", bank_sel, 0);

        low = 0; act = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            if (!hub75_oe) low++;
            if (shift_en || hub75_latch || frame_start || flip_ack) act++;
        end
        expect_int("idle_oe_low", low, 0);
        expect_int("idle_activity", act, 0);

        // First plane at full brightness.
        fs_at = -1; latch_at = -1; first_low = -1; se_cnt = 0; low = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 255, 0, 0);
            if (frame_start && fs_at < 0) fs_at = i;
            if (hub75_latch && latch_at < 0) latch_at = i;
            if (!hub75_oe && first_low < 0) first_low = i;
            if (shift_en) se_cnt++;
            if (!hub75_oe) low++;
            if (i == 99) begin plane99 = plane; col99 = col_addr; end
        end
        expect_int("first_frame_start", fs_at, 0);
        expect_int("first_latch", latch_at, 65);
        expect_int("first_oe_low_at", first_low, 66);
        expect_int("shift_pulses", se_cnt, 64);
        expect_int("plane0_oe_low", low, 31);
        expect_int("next_shift_plane", plane99, 1);
        expect_int("next_shift_col", col99, 0);

        // Dark frame: period unchanged; two flip requests collapse into one flip.
        found = 0;
        for (int i = 0; i < 13000 && found == 0; i++) begin
            step(1, 0, 0, 0);
            if (frame_start) found = 1;
        end
        expect_int("wait_frame_start", found, 1);
        n = 0; found = 0; low = 0; acks = 0;
        while (found == 0 && n < 13000) begin
            step(1, 0, (n == 1000) || (n == 5000), 0);
            n++;
            if (!hub75_oe) low++;
            if (flip_ack) acks++;
            if (frame_start) found = 1;
        end
        expect_int("frame_period", n, 11968);
        expect_int("dark_oe_low", low, 0);
        expect_int("flip_ack_count", acks, 1);
        expect_int("flip_ack_at_frame", flip_ack, 1);
        expect_int("bank_after_flip", bank_sel, 1);

        // Request landing exactly in the frame-end ADVANCE.
        acks = 0; found = 0;
        for (int i = 0; i < 13000 && found == 0; i++) begin
            if (!m_idle && m_row == 15 && m_plane == 3 && m_t == COLS + 2 + win(3)) begin
                found = 1;
            end else begin
                step(1, 90, 0, 0);
                if (flip_ack) acks++;
            end
        end
        expect_int("wait_frame_end", found, 1);
        expect_int("no_spurious_flip", acks, 0);
        step(1, 90, 1, 0);
        expect_int("late_flip_ack", flip_ack, 1);
        expect_int("late_flip_bank", bank_sel, 0);

        // Drop enable mid plane-2 display: window finishes, parks at plane 3.
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (!m_idle && m_plane == 2 && m_t == COLS + 10) found = 1;
            else step(1, 255, 0, 0);
        end
        expect_int("wait_plane2", found, 1);
        row_keep = m_row;
        low = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 255, 0, 0);
            if (!hub75_oe) low++;
        end
        expect_int("drop_tail_low", low, 118);
        expect_int("drop_plane", plane, 3);
        expect_int("drop_row", row_addr, row_keep);
        expect_int("drop_oe", hub75_oe, 1);
        step(1, 255, 0, 0);
        expect_int("resume_no_fs", frame_start, 0);
        expect_int("resume_plane", plane, 3);

        // Reset while the panel is lit.
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            step(1, 255, 0, 0);
            if (!hub75_oe) found = 1;
        end
        expect_int("wait_oe_low", found, 1);
        step(1, 255, 0, 1);
        expect_int("midrst_oe", hub75_oe, 1);
        expect_int("midrst_plane", plane, 0);
        expect_int("midrst_col", col_addr, 0);

        // Brightness table.
        for (int v = 0; v < 10; v++) begin
            found = 0;
            for (int i = 0; i < 1000 && found == 0; i++) begin
                step(1, vecs[v].b, 0, 0);
                if (hub75_latch && plane == vecs[v].p[1:0]) found = 1;
            end
            expect_int("vec_wait_latch", found, 1);
            low = 0;
            for (int i = 0; i < win(vecs[v].p) + 1; i++) begin
                step(1, vecs[v].b, 0, 0);
                if (!hub75_oe) low++;
            end
            expect_int($sformatf("vec%0d_oe_low", v), low, vecs[v].exp_low);
        end

        // Random traffic against the model.
        ren = 1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) ren = !ren;
            step(ren, $urandom_range(0, 255), $urandom_range(0, 299) == 0,
                 $urandom_range(0, 2999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_scan_scheduler.md
Name: hub75_scan_scheduler

Overview:
Sequences the HUB75 panel scan: walks the pixel-RAM read address column by column, gates the panel shift clock, and pulses latch. It then opens a brightness-scaled OE window per bit-plane with binary-weighted duration. It owns the front/back bank select of the double-buffered pixel RAM and flips it only at a frame boundary when the SPI side requests it. It sits between the SPI-written pixel RAM and the panel output pins.

Parameters:
COLUMNS, 64, pixels shifted per row (power of two)
ROW_BITS, 4, panel row-address width (2^ROW_BITS scanned rows)
PLANES, 4, bit-planes per colour channel
BASE_OE, 32, display-window length in cycles for plane 0; plane p window = BASE_OE << p

Ports:
clk  in  1  scheduler clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  run scanning
brightness  in  8  global brightness, 0 = dark, 255 = max
flip_req  in  1  single-cycle pulse: back buffer complete (already in clk domain)
col_addr  out  log2(COLUMNS)  RAM read column
row_addr  out  ROW_BITS  RAM read row and panel row address
plane  out  log2(PLANES)  bit-plane selected from the RAM word
bank_sel  out  1  RAM bank currently displayed
shift_en  out  1  panel clock enable, aligned with RAM read data
hub75_latch  out  1  panel latch
hub75_oe  out  1  panel output enable, active low
flip_ack  out  1  one-cycle pulse when bank_sel toggles
frame_start  out  1  one-cycle pulse at start of row 0 / plane 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (port reset).
- Reset values: state IDLE; col_addr, row_addr, plane = 0; bank_sel = 0; shift_en = 0; hub75_latch = 0; hub75_oe = 1; flip_ack = 0; frame_start = 0; flip pending flag = 0. Reset mid-operation forces these values on the next edge, including hub75_oe = 1.
- RAM read latency is 1 cycle. shift_en is col-address-valid delayed by one register.
- States and transitions:
  - IDLE: hub75_oe = 1. If enable, go to SHIFT with col_addr = 0.
  - SHIFT: col_addr increments each cycle, 0..COLUMNS-1, for COLUMNS cycles. frame_start pulses in the first SHIFT cycle when row = 0 and plane = 0.
  - FLUSH: 1 cycle. Last shift_en is high here.
  - LATCH: 1 cycle. hub75_latch = 1. brightness is sampled here: on_cycles = (window * brightness) >> 8, where window = BASE_OE << plane.
  - DISPLAY: lasts exactly window cycles. hub75_oe = 0 for the first on_cycles cycles, 1 for the rest. Frame period is independent of brightness.
  - ADVANCE: 1 cycle, hub75_oe = 1.
    - plane++. On plane wrap: plane = 0, row_addr++.
    - On row wrap (frame end): if (pending | flip_req), toggle bank_sel, pulse flip_ack, clear pending.
    - Then SHIFT if enable, else IDLE, keeping the advanced row/plane.
- Cycle counts:
  - Per plane: COLUMNS + 3 + (BASE_OE << p).
  - Defaults: row = 748 cycles, frame = 11968 cycles.
- hub75_oe is never low in SHIFT, FLUSH, LATCH, ADVANCE or IDLE. row_addr changes only in ADVANCE, while OE is high.
- flip_req:
  - Sets pending in any state. Multiple requests in one frame collapse to one flip.
  - A request coinciding with the frame-end ADVANCE takes effect that frame.
  - bank_sel never changes except at frame end.
- enable:
  - Sampled only in IDLE and ADVANCE. Deassertion mid-plane completes that plane first.
  - Re-enable resumes at the retained row/plane. frame_start fires only when that position is row 0 / plane 0.
- Arithmetic: window * brightness uses width log2(BASE_OE) + PLANES + 8. Counters wrap modulo their widths.

Decomposition:
- Shared header hub75_defs.vh: state encoding localparams, default geometry (COLUMNS, ROW_BITS, PLANES, BASE_OE).
- One sub-module, hub75_oe_window: loads window and brightness in LATCH, counts DISPLAY cycles, drives hub75_oe and a done flag.

Test Plan:
- Reset, then hold enable = 0 for 20 cycles -> all outputs at reset values, hub75_oe = 1 throughout.
- enable = 1, brightness = 255 -> frame_start in first SHIFT cycle; col_addr 0..63; 64 shift_en pulses lagging by 1; latch high at cycle 65; hub75_oe low 31 cycles, high 1; next SHIFT at cycle 99.
- brightness = 128 on plane 3 -> hub75_oe low 128 of 256 cycles. brightness = 0 -> hub75_oe never low; frame still 11968 cycles.
- flip_req twice mid-frame -> exactly one bank_sel toggle plus one flip_ack, in the frame-end ADVANCE. flip_req in that exact ADVANCE cycle -> toggle same frame.
- Drop enable during plane-2 DISPLAY -> window completes, ADVANCE moves to plane 3, enters IDLE with hub75_oe = 1. Re-enable -> resumes at plane 3 of the same row, no frame_start.
- Assert reset mid-DISPLAY with hub75_oe = 0 -> hub75_oe = 1, bank_sel = 0, row/plane/col = 0 on next edge.
